cv32e40s_fencei_sequencer: RTL and testbench

// - Sequences the fence.i flush handshake on behalf of the controller FSM.
// - The controller issues a one-cycle start when a fence.i retires in WB.
// - The block then waits until the LSU and the write buffer are drained,

---
 rtl/cv32e40s_fencei_sequencer.sv | 93 +++++++++
 tb/tb_cv32e40s_fencei_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_fencei_sequencer.sv
`timescale 1ns/1ps
// fence.i flush handshake sequencer.
// The controller issues a start pulse when a fence.i retires in WB. This block
// waits for the LSU and write buffer to drain, then raises the flush request
// and holds it until it is acknowledged. It then reports completion for one
// cycle so the controller can release WB and branch to pc+4.
module cv32e40s_fencei_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fencei_start_i,
  input  logic             lsu_busy_i,
  input  logic             wbuf_empty_i,
  input  logic             fencei_flush_ack_i,
  output logic             fencei_flush_req_o,
  output logic             fencei_busy_o,
  output logic             fencei_done_o,
  output logic [CNT_W-1:0] fencei_lat_o,
  output logic             fencei_proto_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_DRAIN, REQ, DONE} state_e;

  state_e           state_q, state_n;
  logic             drained;
  logic             req_q, done_q, proto_err_q;
  logic [CNT_W-1:0] lat_q;

  assign drained = !lsu_busy_i && wbuf_empty_i;

  // Next-state decode. A start outside IDLE (including the DONE cycle) is ignored.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:       if (fencei_start_i) state_n = drained ? REQ : WAIT_DRAIN;
      WAIT_DRAIN: if (drained)        state_n = REQ;
      REQ:        if (fencei_flush_ack_i) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // State plus registered req/done, so the pins are glitch-free flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      req_q   <= (state_n == REQ);
      done_q  <= (state_n == DONE);
    end
  end

  // Latency counter: zeroed when REQ is entered, counts REQ cycles, saturates, holds elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (state_q != REQ && state_n == REQ) begin
      lat_q <= '0;
    end else if (state_q == REQ && lat_q != {CNT_W{1'b1}}) begin
      lat_q <= lat_q + 1'b1;
    end
  end

  // Sticky protocol error: an ack is only legal while req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if (fencei_flush_ack_i && !req_q) begin
      proto_err_q <= 1'b1;
    end
  end

  assign fencei_flush_req_o = req_q;
  assign fencei_done_o      = done_q;
  assign fencei_lat_o       = lat_q;
  assign fencei_proto_err_o = proto_err_q;
  // Busy already in the start cycle so WB stalls from the retiring fence.i on.
  assign fencei_busy_o      = (state_q != IDLE) || fencei_start_i;

`ifndef SYNTHESIS
  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (req_q && !fencei_flush_ack_i) |=> req_q);
  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> !done_q);
  a_no_restart : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> !fencei_start_i);
`endif

endmodule

// File: tb/tb_cv32e40s_fencei_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for the fence.i sequencer. Expected waveforms are derived
// from the sequence timeline: d = first drained cycle after start, a = cycles
// the ack is withheld; req spans d+1..d+1+a, done at d+2+a.
module tb_cv32e40s_fencei_sequencer;
  localparam int CNT_W = 4;
  localparam int LMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, lsu_busy, wbuf_empty, ack;
  logic             req, busy, done, proto;
  logic [CNT_W-1:0] lat;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_lat = 0;
  bit exp_proto = 1'b0;

  cv32e40s_fencei_sequencer #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fencei_start_i     (start),
    .lsu_busy_i         (lsu_busy),
    .wbuf_empty_i       (wbuf_empty),
    .fencei_flush_ack_i (ack),
    .fencei_flush_req_o (req),
    .fencei_busy_o      (busy),
    .fencei_done_o      (done),
    .fencei_lat_o       (lat),
    .fencei_proto_err_o (proto)
  );

  always #5 clk = ~clk;

  function automatic int min_i(int x, int y);
    return (x < y) ? x : y;
  endfunction

  // Drive drained/not-drained using either the LSU or the write buffer as the cause.
  task automatic set_drain(bit drn, int src);
    int s;
    s = (src == 2) ? int'($urandom_range(0, 1)) : src;
    if (drn) begin
      lsu_busy = 1'b0; wbuf_empty = 1'b1;
    end else if (s == 0) begin
      lsu_busy = 1'b1; wbuf_empty = 1'($urandom_range(0, 1));
    end else begin
      wbuf_empty = 1'b0; lsu_busy = 1'($urandom_range(0, 1));
    end
  endtask

  // One full sequence. dforce: cycle by which drain is forced; noisy: drained may
  // appear earlier at random (the first drained cycle is what counts).
  task automatic run_seq(string nm, int dforce, int a, int src, bit noisy);
    int  d;
    bit  drn, e_req, e_done, e_busy;
    int  e_lat;
    d = -1;
    for (int k = 0; d < 0 || k <= d + 3 + a; k++) begin
      @(posedge clk); #1;
      start = (k == 0);
      if (d < 0) begin
        drn = (k >= dforce) || (noisy && $urandom_range(0, 2) == 0);
        if (drn) d = k;
      end else begin
        drn = 1'($urandom_range(0, 1));
      end
      set_drain(drn, src);
      ack = (d >= 0 && k == d + 1 + a);
      e_req  = (d >= 0 && k > d && k <= d + 1 + a);
      e_done = (d >= 0 && k == d + 2 + a);
      e_busy = !(d >= 0 && k > d + 2 + a);
      if (e_req)                     e_lat = min_i(k - d - 1, LMAX);
      else if (d >= 0 && k > d + 1 + a) e_lat = min_i(a + 1, LMAX);
      else                           e_lat = exp_lat;
      @(negedge clk);
      n_cmp++;
      if (req !== e_req || done !== e_done || busy !== e_busy ||
          int'(lat) != e_lat || proto !== exp_proto) begin
        n_bad++;
        $display("FAIL %s c%0d: req/done/busy/lat/perr got %b%b%b/%0d/%b want %b%b%b/%0d/%b",
                 nm, k, req, done, busy, lat, proto, e_req, e_done, e_busy, e_lat, exp_proto);
      end
    end
    exp_lat = min_i(a + 1, LMAX);
    start = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; lsu_busy = 1'b0; wbuf_empty = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lat !== '0 || proto !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: req=%b busy=%b done=%b lat=%0d perr=%b want all 0", req, busy, done, lat, proto);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_lat = 0; exp_proto = 1'b0;
  endtask

  task automatic test_directed();
    run_seq("best_case", 0, 0, 0, 1'b0);    // lat=1, done at c2
    run_seq("lsu_busy5", 5, 0, 0, 1'b0);    // req at c6
    run_seq("wbuf3_ack4", 3, 3, 1, 1'b0);   // lat=4
    run_seq("saturate", 0, 19, 2, 1'b0);    // 20 req cycles, lat=15
    run_seq("exact_sat", 2, 14, 2, 1'b0);   // exactly 15 req cycles
  endtask

  task automatic test_proto_err();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    exp_proto = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (proto !== 1'b1 || req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || int'(lat) != exp_lat) begin
      n_bad++;
      $display("FAIL proto_idle: perr=%b req=%b busy=%b done=%b lat=%0d want 1 0 0 0 %0d",
               proto, req, busy, done, lat, exp_lat);
    end
    run_seq("after_proto", 1, 2, 2, 1'b0);
  endtask

  task automatic test_mid_reset();
    int k;
    @(posedge clk); #1 start = 1'b1; set_drain(1'b1, 0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_pre: req=%b want 1", req);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req !== 1'b0 || busy !== 1'b0 || lat !== '0 || proto !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_async: req=%b busy=%b lat=%0d perr=%b want 0 0 0 0", req, busy, lat, proto);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_lat = 0; exp_proto = 1'b0;
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || req !== 1'b0) k++;
    end
    n_cmp++;
    if (k != 0) begin
      n_bad++;
      $display("FAIL mid_reset_quiet: %0d cycles with done/req high, want 0", k);
    end
    run_seq("post_reset", 2, 1, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_seq("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
              2, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_0", 0, 0, 2, 1'b0);
    run_seq("b2b_1", 0, 0, 2, 1'b0);
    run_seq("b2b_2", 1, 0, 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_proto_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
